// File: rtl/icache_ctrl_bank_sync_if.sv
// Bus between the icache control unit / bank array and the bank sync block.
// The slave modport is the sync block's view; master is the environment's.
interface icache_ctrl_bank_sync_if #(
    parameter int NB_CACHE_BANKS = 8,
    parameter int NB_CORES       = 8,
    parameter int CNT_W          = 32
);
    logic                      bypass_req_i;
    logic [NB_CORES:0]         bypass_ack_o;
    logic                      flush_req_i;
    logic                      flush_ack_o;
    logic                      sel_flush_req_i;
    logic [31:0]               sel_flush_addr_i;
    logic                      sel_flush_ack_o;
    logic                      ctrl_clear_regs_i;
    logic                      ctrl_enable_regs_i;
    logic [CNT_W-1:0]          ctrl_hit_count_o;
    logic [CNT_W-1:0]          ctrl_trans_count_o;
    logic [NB_CACHE_BANKS-1:0] bank_bypass_req_o;
    logic [NB_CACHE_BANKS-1:0] bank_bypass_ack_i;
    logic [NB_CACHE_BANKS-1:0] bank_flush_req_o;
    logic [NB_CACHE_BANKS-1:0] bank_flush_ack_i;
    logic [NB_CACHE_BANKS-1:0] bank_sel_flush_req_o;
    logic [31:0]               bank_sel_flush_addr_o;
    logic [NB_CACHE_BANKS-1:0] bank_sel_flush_ack_i;
    logic [NB_CACHE_BANKS-1:0] bank_hit_i;
    logic [NB_CACHE_BANKS-1:0] bank_trans_i;

    modport slave (
        input  bypass_req_i, flush_req_i, sel_flush_req_i, sel_flush_addr_i,
               ctrl_clear_regs_i, ctrl_enable_regs_i, bank_bypass_ack_i,
               bank_flush_ack_i, bank_sel_flush_ack_i, bank_hit_i, bank_trans_i,
        output bypass_ack_o, flush_ack_o, sel_flush_ack_o, ctrl_hit_count_o,
               ctrl_trans_count_o, bank_bypass_req_o, bank_flush_req_o,
               bank_sel_flush_req_o, bank_sel_flush_addr_o
    );

    modport master (
        output bypass_req_i, flush_req_i, sel_flush_req_i, sel_flush_addr_i,
               ctrl_clear_regs_i, ctrl_enable_regs_i, bank_bypass_ack_i,
               bank_flush_ack_i, bank_sel_flush_ack_i, bank_hit_i, bank_trans_i,
        input  bypass_ack_o, flush_ack_o, sel_flush_ack_o, ctrl_hit_count_o,
               ctrl_trans_count_o, bank_bypass_req_o, bank_flush_req_o,
               bank_sel_flush_req_o, bank_sel_flush_addr_o
    );
endinterface

// File: rtl/icache_ctrl_bank_sync.sv
// Fans bypass/flush/selective-flush requests out to the icache banks, merges the
// per-bank acks into one 4-phase ack, and keeps saturating hit/transaction counters.
module icache_ctrl_bank_sync #(
    parameter int NB_CACHE_BANKS = 8,
    parameter int NB_CORES       = 8,
    parameter int CNT_W          = 32
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    icache_ctrl_bank_sync_if.slave bus
);
    localparam int PW = $clog2(NB_CACHE_BANKS + 1);

    typedef enum logic [1:0] {IDLE, FLUSH, SEL_FLUSH, DONE} state_t;

    state_t                    state_q;
    logic [NB_CACHE_BANKS-1:0] pending_q, flush_req_q, sel_req_q, byp_req_q;
    logic [NB_CACHE_BANKS-1:0] flush_done, sel_done, pending_nxt;
    logic [NB_CORES:0]         byp_ack_q;
    logic [31:0]               sel_addr_q;
    logic                      sel_origin_q, flush_ack_q, sel_ack_q, orig_req;
    logic [CNT_W-1:0]          hit_q, trans_q;

    function automatic logic [PW-1:0] popcount(input logic [NB_CACHE_BANKS-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < NB_CACHE_BANKS; i++) c = c + PW'(v[i]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PW-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W + 1 - PW){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Req bits are only set in their own state, so OR-ing both done vectors is safe.
    assign flush_done  = flush_req_q & bus.bank_flush_ack_i;
    assign sel_done    = sel_req_q & bus.bank_sel_flush_ack_i;
    assign pending_nxt = pending_q & ~(flush_done | sel_done);
    assign orig_req    = sel_origin_q ? bus.sel_flush_req_i : bus.flush_req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byp_req_q <= '1;
            byp_ack_q <= '1;
        end else begin
            byp_req_q <= {NB_CACHE_BANKS{bus.bypass_req_i}};
            if (&bus.bank_bypass_ack_i)       byp_ack_q <= '1;
            else if (~|bus.bank_bypass_ack_i) byp_ack_q <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            flush_req_q  <= '0;
            sel_req_q    <= '0;
            sel_addr_q   <= '0;
            sel_origin_q <= 1'b0;
            flush_ack_q  <= 1'b0;
            sel_ack_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.flush_req_i) begin
                        state_q      <= FLUSH;
                        pending_q    <= '1;
                        flush_req_q  <= '1;
                        sel_origin_q <= 1'b0;
                    end else if (bus.sel_flush_req_i) begin
                        state_q      <= SEL_FLUSH;
                        pending_q    <= '1;
                        sel_req_q    <= '1;
                        sel_addr_q   <= bus.sel_flush_addr_i;
                        sel_origin_q <= 1'b1;
                    end
                end
                FLUSH, SEL_FLUSH: begin
                    pending_q   <= pending_nxt;
                    flush_req_q <= flush_req_q & ~flush_done;
                    sel_req_q   <= sel_req_q & ~sel_done;
                    if (pending_nxt == '0) state_q <= DONE;
                end
                DONE: begin
                    // A request withdrawn early never sees its ack: we fall straight to IDLE.
                    if (orig_req) begin
                        flush_ack_q <= 1'b1;
                        sel_ack_q   <= sel_origin_q;
                    end else begin
                        flush_ack_q <= 1'b0;
                        sel_ack_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_q   <= '0;
            trans_q <= '0;
        end else if (bus.ctrl_clear_regs_i) begin
            hit_q   <= '0;
            trans_q <= '0;
        end else if (bus.ctrl_enable_regs_i) begin
            hit_q   <= sat_add(hit_q, popcount(bus.bank_hit_i));
            trans_q <= sat_add(trans_q, popcount(bus.bank_trans_i));
        end
    end

    assign bus.bank_bypass_req_o     = byp_req_q;
    assign bus.bypass_ack_o          = byp_ack_q;
    assign bus.bank_flush_req_o      = flush_req_q;
    assign bus.bank_sel_flush_req_o  = sel_req_q;
    assign bus.bank_sel_flush_addr_o = sel_addr_q;
    assign bus.flush_ack_o           = flush_ack_q;
    assign bus.sel_flush_ack_o       = sel_ack_q;
    assign bus.ctrl_hit_count_o      = hit_q;
    assign bus.ctrl_trans_count_o    = trans_q;
endmodule

// File: tb/tb_icache_ctrl_bank_sync.sv
// Bench for icache_ctrl_bank_sync: directed handshakes with random bank timing,
// plus random bypass/counter traffic against a cycle-level reference model.
module tb_icache_ctrl_bank_sync;
    localparam int NB = 8;
    localparam int NC = 8;
    localparam int CW = 32;
    localparam int SW = 8;   // narrow twin instance makes saturation reachable

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    icache_ctrl_bank_sync_if #(.NB_CACHE_BANKS(NB), .NB_CORES(NC), .CNT_W(CW)) bus ();
    icache_ctrl_bank_sync_if #(.NB_CACHE_BANKS(NB), .NB_CORES(NC), .CNT_W(SW)) bus_s ();

    icache_ctrl_bank_sync #(.NB_CACHE_BANKS(NB), .NB_CORES(NC), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
    icache_ctrl_bank_sync #(.NB_CACHE_BANKS(NB), .NB_CORES(NC), .CNT_W(SW)) dut_s (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_s));

    assign bus_s.bypass_req_i         = bus.bypass_req_i;
    assign bus_s.flush_req_i          = bus.flush_req_i;
    assign bus_s.sel_flush_req_i      = bus.sel_flush_req_i;
    assign bus_s.sel_flush_addr_i     = bus.sel_flush_addr_i;
    assign bus_s.ctrl_clear_regs_i    = bus.ctrl_clear_regs_i;
    assign bus_s.ctrl_enable_regs_i   = bus.ctrl_enable_regs_i;
    assign bus_s.bank_bypass_ack_i    = bus.bank_bypass_ack_i;
    assign bus_s.bank_flush_ack_i     = bus.bank_flush_ack_i;
    assign bus_s.bank_sel_flush_ack_i = bus.bank_sel_flush_ack_i;
    assign bus_s.bank_hit_i           = bus.bank_hit_i;
    assign bus_s.bank_trans_i         = bus.bank_trans_i;

    int n_cmp = 0;
    int n_err = 0;
    bit rand_misc = 1'b0;
    int dly[NB];

    // reference model state
    logic [NC:0]   byp_ack_m;
    logic [NB-1:0] byp_req_m;
    longint        hit_m, trans_m, hit_sm, trans_sm;

    function automatic longint sat(input longint a, input int b, input longint mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        if (!rst_ni) begin
            byp_req_m = '1; byp_ack_m = '1;
            hit_m = 0; trans_m = 0; hit_sm = 0; trans_sm = 0;
        end else begin
            byp_req_m = {NB{bus.bypass_req_i}};
            if (bus.bank_bypass_ack_i == {NB{1'b1}})      byp_ack_m = '1;
            else if (bus.bank_bypass_ack_i == {NB{1'b0}}) byp_ack_m = '0;
            if (bus.ctrl_clear_regs_i) begin
                hit_m = 0; trans_m = 0; hit_sm = 0; trans_sm = 0;
            end else if (bus.ctrl_enable_regs_i) begin
                hit_m    = sat(hit_m,    $countones(bus.bank_hit_i),   64'hFFFF_FFFF);
                trans_m  = sat(trans_m,  $countones(bus.bank_trans_i), 64'hFFFF_FFFF);
                hit_sm   = sat(hit_sm,   $countones(bus.bank_hit_i),   64'hFF);
                trans_sm = sat(trans_sm, $countones(bus.bank_trans_i), 64'hFF);
            end
        end
    endtask

    task automatic check_misc();
        chk("bank_bypass_req", bus.bank_bypass_req_o, byp_req_m);
        chk("bypass_ack", bus.bypass_ack_o, byp_ack_m);
        chk("hit_count", bus.ctrl_hit_count_o, hit_m);
        chk("trans_count", bus.ctrl_trans_count_o, trans_m);
        chk("hit_count_narrow", bus_s.ctrl_hit_count_o, hit_sm);
        chk("trans_count_narrow", bus_s.ctrl_trans_count_o, trans_sm);
    endtask

    task automatic randomize_misc();
        bus.bypass_req_i = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
            0:       bus.bank_bypass_ack_i = '0;
            1:       bus.bank_bypass_ack_i = '1;
            default: bus.bank_bypass_ack_i = NB'($urandom);
        endcase
        bus.ctrl_clear_regs_i  = ($urandom_range(0, 15) == 0);
        bus.ctrl_enable_regs_i = ($urandom_range(0, 3) != 0);
        bus.bank_hit_i         = NB'($urandom);
        bus.bank_trans_i       = NB'($urandom);
    endtask

    task automatic tick();
        if (rand_misc) randomize_misc();
        model_update();
        @(posedge clk_i);
        #1;
        check_misc();
    endtask

    // Called in the first cycle the bank requests are visible. Bank i acks from cycle dly[i].
    task automatic flush_body(input bit sel);
        int d_max;
        d_max = 0;
        for (int i = 0; i < NB; i++) if (dly[i] > d_max) d_max = dly[i];
        for (int t = 0; t <= d_max + 3; t++) begin
            logic [NB-1:0] ack_v, exp_req;
            for (int i = 0; i < NB; i++) begin
                ack_v[i]   = (t >= dly[i]);
                exp_req[i] = (t <= dly[i]);
            end
            if (sel) begin
                bus.bank_sel_flush_ack_i = ack_v;
                bus.bank_flush_ack_i     = NB'($urandom);
                chk("sel_bank_req", bus.bank_sel_flush_req_o, exp_req);
                chk("idle_flush_bank_req", bus.bank_flush_req_o, 0);
            end else begin
                bus.bank_flush_ack_i     = ack_v;
                bus.bank_sel_flush_ack_i = NB'($urandom);
                chk("flush_bank_req", bus.bank_flush_req_o, exp_req);
                chk("idle_sel_bank_req", bus.bank_sel_flush_req_o, 0);
            end
            chk("flush_ack", bus.flush_ack_o, (t >= d_max + 2));
            chk("sel_flush_ack", bus.sel_flush_ack_o, (sel && t >= d_max + 2));
            tick();
        end
    endtask

    task automatic flush_end(input bit sel);
        if (sel) bus.sel_flush_req_i = 1'b0; else bus.flush_req_i = 1'b0;
        bus.bank_flush_ack_i = '0;
        bus.bank_sel_flush_ack_i = '0;
        tick();
        chk("ack_drop_flush", bus.flush_ack_o, 0);
        chk("ack_drop_sel", bus.sel_flush_ack_o, 0);
        tick();
        chk("idle_flush_req", bus.bank_flush_req_o, 0);
        chk("idle_sel_req", bus.bank_sel_flush_req_o, 0);
    endtask

    initial begin
        rst_ni = 1'b0;
        bus.bypass_req_i = 1'b1;       bus.bank_bypass_ack_i = '1;
        bus.flush_req_i = 1'b0;        bus.sel_flush_req_i = 1'b0;
        bus.sel_flush_addr_i = '0;     bus.ctrl_clear_regs_i = 1'b0;
        bus.ctrl_enable_regs_i = 1'b0; bus.bank_flush_ack_i = '0;
        bus.bank_sel_flush_ack_i = '0; bus.bank_hit_i = '0;
        bus.bank_trans_i = '0;

        // reset state
        tick();
        tick();
        chk("rst_bank_bypass_req", bus.bank_bypass_req_o, 8'hFF);
        chk("rst_bypass_ack", bus.bypass_ack_o, 9'h1FF);
        chk("rst_flush_req", bus.bank_flush_req_o, 0);
        chk("rst_sel_addr", bus.bank_sel_flush_addr_o, 0);
        chk("rst_acks", {bus.flush_ack_o, bus.sel_flush_ack_o}, 0);
        rst_ni = 1'b1;
        tick();

        // bypass release with staggered bank acks
        bus.bypass_req_i = 1'b0;
        tick();
        chk("bypass_req_drop", bus.bank_bypass_req_o, 8'h00);
        bus.bank_bypass_ack_i = 8'hFC; tick();
        bus.bank_bypass_ack_i = 8'hF0; tick();
        chk("bypass_ack_hold_mid", bus.bypass_ack_o, 9'h1FF);
        bus.bank_bypass_ack_i = 8'hC0; tick();
        chk("bypass_ack_hold_late", bus.bypass_ack_o, 9'h1FF);
        bus.bank_bypass_ack_i = 8'h00; tick();
        chk("bypass_ack_all_enabled", bus.bypass_ack_o, 9'h000);

        // counters: clear beats strobes, accumulation, saturation, disable
        bus.ctrl_clear_regs_i = 1'b1; bus.ctrl_enable_regs_i = 1'b1;
        bus.bank_hit_i = 8'hFF; bus.bank_trans_i = 8'h0F;
        tick();
        chk("clear_with_strobes", bus.ctrl_hit_count_o, 0);
        bus.ctrl_clear_regs_i = 1'b0;
        repeat (3) tick();
        chk("hit_24", bus.ctrl_hit_count_o, 24);
        chk("trans_12", bus.ctrl_trans_count_o, 12);
        repeat (30) tick();
        chk("hit_saturate_narrow", bus_s.ctrl_hit_count_o, 8'hFF);
        chk("hit_wide_no_sat", bus.ctrl_hit_count_o, 264);
        bus.ctrl_enable_regs_i = 1'b0;
        tick();
        chk("disabled_hold", bus.ctrl_hit_count_o, 264);
        bus.ctrl_clear_regs_i = 1'b1; bus.ctrl_enable_regs_i = 1'b1;
        tick();
        chk("clear_after_sat", bus_s.ctrl_hit_count_o, 0);
        bus.ctrl_clear_regs_i = 1'b0;

        // random bypass/counter traffic
        rand_misc = 1'b1;
        repeat (150) tick();

        // full flush, bank i acks at cycle i
        for (int i = 0; i < NB; i++) dly[i] = i;
        bus.flush_req_i = 1'b1;
        tick();
        flush_body(1'b0);
        flush_end(1'b0);

        // flush and selective flush raised together: flush first, then sel
        bus.flush_req_i = 1'b1;
        bus.sel_flush_req_i = 1'b1;
        bus.sel_flush_addr_i = 32'h1C008040;
        for (int i = 0; i < NB; i++) dly[i] = int'($urandom_range(0, 4));
        tick();
        flush_body(1'b0);
        bus.flush_req_i = 1'b0;
        bus.bank_flush_ack_i = '0;
        bus.bank_sel_flush_ack_i = '0;
        tick();
        chk("combo_ack_drop", bus.flush_ack_o, 0);
        chk("combo_sel_not_yet", bus.bank_sel_flush_req_o, 0);
        tick();
        flush_body(1'b1);
        chk("combo_sel_addr", bus.bank_sel_flush_addr_o, 32'h1C008040);
        flush_end(1'b1);

        // random flush / sel flush sequences
        for (int k = 0; k < 6; k++) begin
            bit sel;
            logic [31:0] addr;
            sel = 1'($urandom_range(0, 1));
            addr = $urandom;
            for (int i = 0; i < NB; i++) dly[i] = int'($urandom_range(0, 5));
            bus.sel_flush_addr_i = addr;
            if (sel) bus.sel_flush_req_i = 1'b1; else bus.flush_req_i = 1'b1;
            tick();
            flush_body(sel);
            if (sel) chk("rand_sel_addr", bus.bank_sel_flush_addr_o, addr);
            flush_end(sel);
        end

        // async reset during a flush with banks 5..7 still pending
        for (int i = 0; i < NB; i++) dly[i] = (i < 5) ? i : 1000;
        bus.flush_req_i = 1'b1;
        tick();
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NB; i++) bus.bank_flush_ack_i[i] = (t >= dly[i]);
            tick();
        end
        chk("pending_three", bus.bank_flush_req_o, 8'hE0);
        rst_ni = 1'b0;
        #1;
        chk("async_rst_flush_req", bus.bank_flush_req_o, 0);
        chk("async_rst_flush_ack", bus.flush_ack_o, 0);
        model_update();
        check_misc();
        bus.flush_req_i = 1'b0;
        bus.bank_flush_ack_i = '0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        for (int i = 0; i < NB; i++) dly[i] = int'($urandom_range(0, 3));
        bus.flush_req_i = 1'b1;
        tick();
        flush_body(1'b0);
        flush_end(1'b0);

        rand_misc = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
